// File: rtl/fractal_sync_pkg.sv
// fractal_sync_pkg: shared request struct templates and index-width helper.
// Holds the default in/out request types used by the fractal sync receivers:
// the outgoing request carries one aggregation bit fewer than the incoming one.
package fractal_sync_pkg;
  localparam int unsigned FSYNC_AW  = 4;
  localparam int unsigned FSYNC_IDW = 8;
  typedef struct packed {
    logic [FSYNC_AW-1:0]  aggr;
    logic [FSYNC_IDW-1:0] id;
  } fsync_in_sig_t;
  typedef struct packed {
    logic          sync;
    fsync_in_sig_t sig;
  } fsync_in_req_t;
  typedef struct packed {
    logic [FSYNC_AW-2:0]  aggr;
    logic [FSYNC_IDW-1:0] id;
  } fsync_out_sig_t;
  typedef struct packed {
    logic           sync;
    fsync_out_sig_t sig;
  } fsync_out_req_t;
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fractal_sync_fifo.sv
// fractal_sync_fifo: circular storage for sync requests.
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/data_i write
// the tail; pop_i retires the head; data_o shows the head. Occupancy is tracked
// by the instantiating module, which never pushes into a full FIFO without a pop.
module fractal_sync_fifo
  import fractal_sync_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type data_t = logic,
  localparam int unsigned PW = idx_w(DEPTH)
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  push_i,
  input  data_t data_i,
  input  logic  pop_i,
  output data_t data_o
);
  data_t mem_q [DEPTH];
  data_t mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] v);
    return (v == PW'(DEPTH - 1)) ? '0 : v + 1'b1;
  endfunction

  // Push into a full FIFO only happens together with a pop, in which case
  // wr_q == rd_q and the new tail overwrites the slot being retired.
  always_comb begin
    mem_d = mem_q;
    if (push_i) mem_d[wr_q] = data_i;
    wr_d = push_i ? nxt(wr_q) : wr_q;
    rd_d = pop_i ? nxt(rd_q) : rd_q;
  end

  assign data_o = mem_q[rd_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end
endmodule

// File: rtl/fractal_sync_rr_arb.sv
// fractal_sync_rr_arb: round-robin arbiter with grant hold.
// Ports: req_i request vector; hold_i freezes the current grant for the next
// cycle (presented but not accepted); adv_i moves priority to grant+1;
// valid_o any request; idx_o granted index.
module fractal_sync_rr_arb
  import fractal_sync_pkg::*;
#(
  parameter int unsigned N = 2,
  localparam int unsigned IW = idx_w(N)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [N-1:0]  req_i,
  input  logic          hold_i,
  input  logic          adv_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);
  logic [IW-1:0] ptr_q, ptr_d, idx_q, idx_d, pick;
  logic lock_q, lock_d;

  assign valid_o = |req_i;

  // Scanning from lowest priority upward lets the last hit (highest priority) win.
  always_comb begin
    pick = ptr_q;
    for (int i = int'(N) - 1; i >= 0; i--)
      if (req_i[IW'((int'(ptr_q) + i) % int'(N))]) pick = IW'((int'(ptr_q) + i) % int'(N));
    idx_o  = lock_q ? idx_q : pick;
    idx_d  = idx_o;
    lock_d = hold_i;
    ptr_d  = adv_i ? ((idx_o == IW'(N - 1)) ? '0 : idx_o + 1'b1) : ptr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q  <= '0;
      idx_q  <= '0;
      lock_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      idx_q  <= idx_d;
      lock_q <= lock_d;
    end
  end
endmodule

// File: rtl/fractal_sync_mp_rx.sv
// fractal_sync_mp_rx: multi-port sync request receiver.
// Each port samples its request, flags local/root termination, and queues
// non-local requests (aggr shifted down one level) into a per-port FIFO.
// A round-robin arbiter presents one FIFO head on valid_o/req_o/port_o.
// Ports: req_i/sampled_req_o per-port in/sampled requests; check_propagate_o,
// local_o, root_o per-port sampled flags; error_overflow_o/clr_error_i sticky
// overflow per port; valid_o/ready_i/req_o/port_o output handshake;
// level_o per-port FIFO occupancy.
module fractal_sync_mp_rx
  import fractal_sync_pkg::*;
#(
  parameter type fsync_req_in_t  = fractal_sync_pkg::fsync_in_req_t,
  parameter type fsync_req_out_t = fractal_sync_pkg::fsync_out_req_t,
  parameter int unsigned N_PORTS    = 2,
  parameter bit          COMB_IN    = 1'b0,
  parameter int unsigned FIFO_DEPTH = 2,
  localparam int unsigned IW = idx_w(N_PORTS),
  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  fsync_req_in_t  [N_PORTS-1:0]   req_i,
  output fsync_req_in_t  [N_PORTS-1:0]   sampled_req_o,
  output logic           [N_PORTS-1:0]   check_propagate_o,
  output logic           [N_PORTS-1:0]   local_o,
  output logic           [N_PORTS-1:0]   root_o,
  output logic           [N_PORTS-1:0]   error_overflow_o,
  input  logic           [N_PORTS-1:0]   clr_error_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output fsync_req_out_t                 req_o,
  output logic           [IW-1:0]        port_o,
  output logic [N_PORTS-1:0][LW-1:0]     level_o
);
  localparam int AW_IN  = $bits(req_i[0].sig.aggr);
  localparam int AW_OUT = $bits(req_o.sig.aggr);

  if (N_PORTS == 0) begin : g_err_ports
    $error("N_PORTS must be at least 1");
  end
  if (FIFO_DEPTH == 0) begin : g_err_depth
    $error("FIFO_DEPTH must be at least 1");
  end
  if (AW_OUT != AW_IN - 1) begin : g_err_aggr
    $error("output aggr width must be input aggr width - 1");
  end

  logic [N_PORTS-1:0] sync_s, push, pop, accept, full, nonempty;
  fsync_req_out_t head [N_PORTS];

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    fsync_req_out_t elem;
    logic [LW-1:0] level_q, level_d;
    logic err_q, err_d;
    if (COMB_IN) begin : g_comb
      assign sync_s[p]        = req_i[p].sync & rst_ni;
      assign sampled_req_o[p] = req_i[p];
    end else begin : g_reg
      logic sync_q, sync_d;
      fsync_req_in_t req_q, req_d;
      always_comb begin
        sync_d = req_i[p].sync;
        req_d  = req_i[p].sync ? req_i[p] : req_q;
      end
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          sync_q <= 1'b0;
          req_q  <= '0;
        end else begin
          sync_q <= sync_d;
          req_q  <= req_d;
        end
      end
      assign sync_s[p]        = sync_q;
      assign sampled_req_o[p] = req_q;
    end
    assign check_propagate_o[p] = sync_s[p];
    assign local_o[p]  = sync_s[p] & sampled_req_o[p].sig.aggr[0];
    assign root_o[p]   = sync_s[p] & (sampled_req_o[p].sig.aggr == AW_IN'(1));
    assign push[p]     = sync_s[p] & ~sampled_req_o[p].sig.aggr[0];
    assign pop[p]      = valid_o & ready_i & (port_o == IW'(p));
    assign full[p]     = level_q == LW'(FIFO_DEPTH);
    assign nonempty[p] = level_q != '0;
    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    assign accept[p]   = push[p] & (~full[p] | pop[p]);
    always_comb begin
      elem          = '0;
      elem.sync     = sampled_req_o[p].sync;
      elem.sig.aggr = sampled_req_o[p].sig.aggr[AW_IN-1:1];
      elem.sig.id   = sampled_req_o[p].sig.id;
      level_d = (accept[p] & ~pop[p]) ? level_q + 1'b1 :
                (pop[p] & ~accept[p]) ? level_q - 1'b1 : level_q;
      err_d   = (push[p] & full[p] & ~pop[p]) | (err_q & ~clr_error_i[p]);
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        level_q <= '0;
        err_q   <= 1'b0;
      end else begin
        level_q <= level_d;
        err_q   <= err_d;
      end
    end
    assign level_o[p]          = level_q;
    assign error_overflow_o[p] = err_q;
    fractal_sync_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .data_t (fsync_req_out_t)
    ) i_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push_i (accept[p]),
      .data_i (elem),
      .pop_i  (pop[p]),
      .data_o (head[p])
    );
  end

  // Holding while presented-but-not-accepted keeps req_o/port_o stable even
  // when a higher-priority port becomes non-empty in the meantime.
  fractal_sync_rr_arb #(
    .N (N_PORTS)
  ) i_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (nonempty),
    .hold_i  (valid_o & ~ready_i),
    .adv_i   (valid_o & ready_i),
    .valid_o (valid_o),
    .idx_o   (port_o)
  );

  assign req_o = head[port_o];
endmodule

// File: tb/tb_fractal_sync_mp_rx.sv
// tb_fractal_sync_mp_rx: table vectors, corner sequences and a queue-based random model.
module tb_fractal_sync_mp_rx;
  import fractal_sync_pkg::*;
  localparam int N = 2, D = 2, LW = $clog2(D + 1);

  logic clk_i = 1'b0, rst_ni = 1'b0;
  fsync_in_req_t  [N-1:0] req_i, sampled_req_o;
  logic [N-1:0] check_propagate_o, local_o, root_o, error_overflow_o, clr_error_i;
  logic valid_o, ready_i;
  fsync_out_req_t req_o;
  logic [0:0] port_o;
  logic [N-1:0][LW-1:0] level_o;
  int checks = 0, errors = 0;

  always #5 clk_i = ~clk_i;

  fractal_sync_mp_rx #(
    .fsync_req_in_t  (fsync_in_req_t),
    .fsync_req_out_t (fsync_out_req_t),
    .N_PORTS    (N),
    .COMB_IN    (1'b0),
    .FIFO_DEPTH (D)
  ) dut (
    .clk_i (clk_i), .rst_ni (rst_ni), .req_i (req_i), .sampled_req_o (sampled_req_o),
    .check_propagate_o (check_propagate_o), .local_o (local_o), .root_o (root_o),
    .error_overflow_o (error_overflow_o), .clr_error_i (clr_error_i),
    .valid_o (valid_o), .ready_i (ready_i), .req_o (req_o), .port_o (port_o), .level_o (level_o)
  );

  typedef struct {
    int p; logic sync; logic [3:0] aggr; logic [7:0] id;
    logic e_loc; logic e_root; logic e_push; logic [2:0] e_aggr;
  } vec_t;
  vec_t vt [8];

  logic           m_ss  [N];
  fsync_in_req_t  m_sr  [N];
  fsync_out_req_t mq    [N][$];
  logic           m_err [N];
  int m_ptr, m_hp;
  logic m_held;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    req_i = '0; clr_error_i = '0; ready_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; idle();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic drv(input int p, input logic [3:0] a, input logic [7:0] id);
    req_i[p].sync = 1'b1; req_i[p].sig.aggr = a; req_i[p].sig.id = id;
  endtask

  function automatic fsync_out_req_t conv(input fsync_in_req_t r);
    fsync_out_req_t o;
    o.sync = r.sync; o.sig.aggr = 3'(r.sig.aggr / 2); o.sig.id = r.sig.id;
    return o;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    vt[0] = '{0, 1'b1, 4'b0110, 8'd5,   1'b0, 1'b0, 1'b1, 3'b011};
    vt[1] = '{1, 1'b1, 4'b0001, 8'd9,   1'b1, 1'b1, 1'b0, 3'b000};
    vt[2] = '{1, 1'b1, 4'b0011, 8'd3,   1'b1, 1'b0, 1'b0, 3'b000};
    vt[3] = '{1, 1'b1, 4'b0010, 8'hA5,  1'b0, 1'b0, 1'b1, 3'b001};
    vt[4] = '{0, 1'b1, 4'b1000, 8'hFF,  1'b0, 1'b0, 1'b1, 3'b100};
    vt[5] = '{0, 1'b1, 4'b0000, 8'd1,   1'b0, 1'b0, 1'b1, 3'b000};
    vt[6] = '{1, 1'b0, 4'b0110, 8'd4,   1'b0, 1'b0, 1'b0, 3'b000};
    vt[7] = '{0, 1'b1, 4'b1111, 8'd2,   1'b1, 1'b0, 1'b0, 3'b000};
    idle();
    #1 chk("rst_valid", 32'(valid_o), 0);
    chk("rst_level", 32'(level_o), 0);
    chk("rst_cp", 32'(check_propagate_o), 0);
    chk("rst_err", 32'(error_overflow_o), 0);
    do_reset();

    for (int v = 0; v < 8; v++) begin
      @(negedge clk_i);
      req_i = '0;
      req_i[vt[v].p].sync = vt[v].sync;
      req_i[vt[v].p].sig.aggr = vt[v].aggr;
      req_i[vt[v].p].sig.id = vt[v].id;
      @(negedge clk_i);
      req_i = '0;
      chk($sformatf("v%0d_cp", v), 32'(check_propagate_o[vt[v].p]), 32'(vt[v].sync));
      chk($sformatf("v%0d_local", v), 32'(local_o[vt[v].p]), 32'(vt[v].e_loc));
      chk($sformatf("v%0d_root", v), 32'(root_o[vt[v].p]), 32'(vt[v].e_root));
      chk($sformatf("v%0d_early_valid", v), 32'(valid_o), 0);
      if (vt[v].sync) chk($sformatf("v%0d_sampled_id", v), 32'(sampled_req_o[vt[v].p].sig.id), 32'(vt[v].id));
      @(negedge clk_i);
      chk($sformatf("v%0d_valid", v), 32'(valid_o), 32'(vt[v].e_push));
      chk($sformatf("v%0d_level", v), 32'(level_o[vt[v].p]), 32'(vt[v].e_push));
      if (vt[v].e_push) begin
        chk($sformatf("v%0d_port", v), 32'(port_o), 32'(vt[v].p));
        chk($sformatf("v%0d_aggr", v), 32'(req_o.sig.aggr), 32'(vt[v].e_aggr));
        chk($sformatf("v%0d_id", v), 32'(req_o.sig.id), 32'(vt[v].id));
        chk($sformatf("v%0d_sync", v), 32'(req_o.sync), 1);
      end
      ready_i = 1'b1;
      @(negedge clk_i);
      ready_i = 1'b0;
      chk($sformatf("v%0d_drained", v), 32'(valid_o), 0);
      chk($sformatf("v%0d_level0", v), 32'(level_o[vt[v].p]), 0);
    end

    do_reset();
    ready_i = 1'b1; n = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      if (valid_o) begin
        chk("alt_port", 32'(port_o), 32'(n % 2));
        chk("alt_id", 32'(req_o.sig.id), 32'((n % 2) * 16 + n / 2));
        n++;
      end
      req_i = '0;
      if (c < 3) begin drv(0, 4'b0010, 8'(c)); drv(1, 4'b0010, 8'(16 + c)); end
    end
    chk("alt_count", 32'(n), 6);
    chk("alt_ovf", 32'(error_overflow_o), 0);

    do_reset();
    @(negedge clk_i); drv(0, 4'b0010, 8'd10);
    @(negedge clk_i); req_i = '0; drv(0, 4'b0010, 8'd11);
    @(negedge clk_i); req_i = '0; drv(0, 4'b0010, 8'd12);
    @(negedge clk_i); req_i = '0;
    chk("ovf_pre_err", 32'(error_overflow_o[0]), 0);
    chk("ovf_pre_level", 32'(level_o[0]), 2);
    @(negedge clk_i);
    chk("ovf_level", 32'(level_o[0]), 2);
    chk("ovf_err", 32'(error_overflow_o[0]), 1);
    chk("ovf_head", 32'(req_o.sig.id), 10);
    repeat (2) @(negedge clk_i);
    chk("ovf_sticky", 32'(error_overflow_o[0]), 1);
    clr_error_i[0] = 1'b1;
    @(negedge clk_i); clr_error_i[0] = 1'b0;
    chk("ovf_clr", 32'(error_overflow_o[0]), 0);
    drv(0, 4'b0010, 8'd13);
    @(negedge clk_i); req_i = '0; clr_error_i[0] = 1'b1;
    @(negedge clk_i); clr_error_i[0] = 1'b0;
    chk("ovf_set_wins", 32'(error_overflow_o[0]), 1);
    clr_error_i[0] = 1'b1;
    @(negedge clk_i); clr_error_i[0] = 1'b0;
    chk("ovf_clr2", 32'(error_overflow_o[0]), 0);
    chk("ovf_head2", 32'(req_o.sig.id), 10);
    ready_i = 1'b1;
    @(negedge clk_i);
    chk("ovf_second", 32'(req_o.sig.id), 11);
    chk("ovf_second_v", 32'(valid_o), 1);
    @(negedge clk_i);
    chk("ovf_dropped", 32'(valid_o), 0);
    ready_i = 1'b0;

    do_reset();
    ready_i = 1'b1;
    @(negedge clk_i); drv(0, 4'b0010, 8'd1);
    @(negedge clk_i); req_i = '0;
    @(negedge clk_i);
    chk("hold_pre_port", 32'(port_o), 0);
    chk("hold_pre_id", 32'(req_o.sig.id), 1);
    @(negedge clk_i);
    chk("hold_pre_empty", 32'(valid_o), 0);
    ready_i = 1'b0; drv(0, 4'b0010, 8'd7);
    @(negedge clk_i); req_i = '0;
    @(negedge clk_i);
    chk("hold_valid", 32'(valid_o), 1);
    for (int t = 0; t < 5; t++) begin
      req_i = '0; drv(1, 4'b0010, 8'(20 + t));
      @(negedge clk_i);
      chk("hold_port", 32'(port_o), 0);
      chk("hold_id", 32'(req_o.sig.id), 7);
    end
    req_i = '0; ready_i = 1'b1;
    chk("hold_p1_ovf", 32'(error_overflow_o[1]), 1);
    @(negedge clk_i);
    chk("hold_next_port", 32'(port_o), 1);
    chk("hold_next_id", 32'(req_o.sig.id), 20);
    @(negedge clk_i);
    chk("hold_last_port", 32'(port_o), 1);
    chk("hold_last_id", 32'(req_o.sig.id), 21);
    @(negedge clk_i);
    chk("hold_empty", 32'(valid_o), 0);

    do_reset();
    @(negedge clk_i); drv(0, 4'b0010, 8'd30); drv(1, 4'b0010, 8'd31);
    @(negedge clk_i); req_i = '0; drv(0, 4'b0010, 8'd32);
    @(negedge clk_i); req_i = '0;
    chk("mrst_lvl0", 32'(level_o[0]), 1);
    chk("mrst_lvl1", 32'(level_o[1]), 1);
    chk("mrst_inflight", 32'(check_propagate_o[0]), 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("mrst_valid", 32'(valid_o), 0);
    chk("mrst_level", 32'(level_o), 0);
    chk("mrst_cp", 32'(check_propagate_o), 0);
    @(negedge clk_i); rst_ni = 1'b1; ready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      chk("mrst_quiet", 32'(valid_o), 0);
    end

    do_reset();
    for (int p = 0; p < N; p++) begin
      m_ss[p] = 1'b0; m_sr[p] = '0; m_err[p] = 1'b0; mq[p].delete();
    end
    m_ptr = 0; m_hp = 0; m_held = 1'b0;
    for (int c = 0; c < 400; c++) begin
      int g;
      logic pop;
      @(negedge clk_i);
      g = -1;
      if (m_held) g = m_hp;
      else for (int i = 0; i < N; i++) if (g < 0 && mq[(m_ptr + i) % N].size() > 0) g = (m_ptr + i) % N;
      for (int p = 0; p < N; p++) begin
        chk($sformatf("r_cp%0d", p), 32'(check_propagate_o[p]), 32'(m_ss[p]));
        chk($sformatf("r_loc%0d", p), 32'(local_o[p]), 32'(m_ss[p] & m_sr[p].sig.aggr[0]));
        chk($sformatf("r_root%0d", p), 32'(root_o[p]), 32'(m_ss[p] && m_sr[p].sig.aggr == 4'd1));
        chk($sformatf("r_lvl%0d", p), 32'(level_o[p]), 32'(mq[p].size()));
        chk($sformatf("r_err%0d", p), 32'(error_overflow_o[p]), 32'(m_err[p]));
        chk($sformatf("r_samp%0d", p), 32'(sampled_req_o[p]), 32'(m_sr[p]));
      end
      chk("r_valid", 32'(valid_o), 32'(g >= 0));
      if (g >= 0) begin
        chk("r_port", 32'(port_o), 32'(g));
        chk("r_req", 32'(req_o), 32'(mq[g][0]));
      end
      for (int p = 0; p < N; p++) begin
        req_i[p].sync = ($urandom_range(0, 1) == 1);
        req_i[p].sig.aggr = 4'($urandom);
        req_i[p].sig.id = 8'($urandom);
        clr_error_i[p] = ($urandom_range(0, 7) == 0);
      end
      ready_i = ($urandom_range(0, 1) == 1);
      pop = (g >= 0) && ready_i;
      for (int p = 0; p < N; p++) begin
        logic push, pp, was_full, set;
        push = m_ss[p] && !m_sr[p].sig.aggr[0];
        pp = pop && (g == p);
        was_full = (mq[p].size() == D);
        set = push && was_full && !pp;
        if (pp) void'(mq[p].pop_front());
        if (push && !set) mq[p].push_back(conv(m_sr[p]));
        m_err[p] = set | (m_err[p] & !clr_error_i[p]);
        m_ss[p] = req_i[p].sync;
        if (req_i[p].sync) m_sr[p] = req_i[p];
      end
      if (pop) m_ptr = (g + 1) % N;
      m_held = (g >= 0) && !ready_i;
      m_hp = g;
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
